// File: rtl/trig_acq_ctrl.sv
// N-channel trigger/acquisition controller: window comparators with edge or ToT
// qualification, trigger OR, and a pre/post-trigger ring-buffer write sequencer.

module trig_acq_chan #(
  parameter int DW = 8,
  parameter int AW = 10
)(
  input  logic          clk,
  input  logic          rstn,
  input  logic [DW-1:0] i_x,
  input  logic [DW-1:0] i_thr_lo,
  input  logic [DW-1:0] i_thr_hi,
  input  logic          i_neg,
  input  logic [AW-1:0] i_tot,
  input  logic          i_tot_ds,
  input  logic          i_ds_go,
  output logic          o_trig
);
  logic          r_in1, r_in2, r_trig;
  logic [AW:0]   r_tcnt;
  logic [AW:0]   w_tnext;
  logic          w_edge, w_cond, w_qual;

  assign w_edge  = i_neg ? (~r_in1 & r_in2) : (r_in1 & ~r_in2);
  assign w_cond  = i_neg ? ~r_in1 : r_in1;
  assign w_qual  = ~i_tot_ds | i_ds_go;
  assign w_tnext = r_tcnt + 1'b1;
  assign o_trig  = r_trig;

  // r_tcnt==0 means no ToT run in progress; an edge starts a run at 1
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_in1  <= 1'b0;
      r_in2  <= 1'b0;
      r_tcnt <= '0;
      r_trig <= 1'b0;
    end else begin
      r_in1  <= (i_x >= i_thr_lo) && (i_x <= i_thr_hi);
      r_in2  <= r_in1;
      r_trig <= 1'b0;
      if (i_tot == '0) begin
        r_tcnt <= '0;
        r_trig <= w_edge;
      end else if (r_tcnt == '0) begin
        if (w_edge) r_tcnt <= {{AW{1'b0}}, 1'b1};
      end else if (w_qual) begin
        if (!w_cond) r_tcnt <= '0;
        else if (w_tnext > {1'b0, i_tot}) begin
          r_trig <= 1'b1;
          r_tcnt <= '0;
        end else r_tcnt <= w_tnext;
      end
    end
  end
endmodule

module trig_acq_ctrl #(
  parameter int NCH   = 4,
  parameter int DW    = 8,
  parameter int AW    = 10,
  parameter int DSW   = 4,
  parameter int ROLLW = 25
)(
  input  logic              clk,
  input  logic              rstn,
  input  logic [NCH*DW-1:0] din,
  input  logic              arm,
  input  logic              ack,
  input  logic [DW-1:0]     thr_lo,
  input  logic [DW-1:0]     thr_hi,
  input  logic [NCH-1:0]    trig_en,
  input  logic              trig_neg,
  input  logic [AW-1:0]     tot,
  input  logic              tot_ds,
  input  logic [DSW-1:0]    ds,
  input  logic [AW-1:0]     pretrig,
  input  logic [AW-1:0]     nsmp,
  input  logic              rolling,
  input  logic [ROLLW-1:0]  roll_period,
  input  logic              ext_trig,
  input  logic              ext_en,
  input  logic              trig_in,
  output logic              wr_en,
  output logic [AW-1:0]     wr_addr,
  output logic [NCH*DW-1:0] wr_data,
  output logic [AW-1:0]     trig_addr,
  output logic [NCH-1:0]    chan_trig,
  output logic              selftrig,
  output logic              busy,
  output logic              data_ready
);
  localparam int DSCW = (1 << DSW) - 1;
  localparam logic [1:0] S_IDLE = 2'd0, S_PRE = 2'd1, S_WAIT = 2'd2, S_POST = 2'd3;

  logic [1:0]        r_state;
  logic [AW-1:0]     r_cnt, r_wr_addr, r_trig_addr;
  logic [DSCW-1:0]   r_ds_cnt;
  logic [ROLLW-1:0]  r_roll;
  logic [NCH*DW-1:0] r_wr_data;
  logic              r_wr_en, r_data_ready, r_ext_s1, r_ext_s2;
  logic [DSCW-1:0]   w_ds_lim;
  logic [AW-1:0]     w_post_len;
  logic [NCH-1:0]    w_chan_trig;
  logic              w_ds_go, w_roll_fire, w_trig;

  // >= rather than == so a ds decrease mid-count still produces a strobe
  assign w_ds_lim    = ~({DSCW{1'b1}} << ds);
  assign w_ds_go     = (ds == '0) || (r_ds_cnt >= w_ds_lim);
  assign w_roll_fire = (r_roll >= roll_period);
  assign w_post_len  = (nsmp > pretrig) ? (nsmp - pretrig) : {{(AW-1){1'b0}}, 1'b1};
  assign selftrig    = (|(w_chan_trig & trig_en)) | (ext_en & r_ext_s2) | (rolling & w_roll_fire);
  assign w_trig      = selftrig | trig_in;

  assign wr_en      = r_wr_en;
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;
  assign trig_addr  = r_trig_addr;
  assign chan_trig  = w_chan_trig;
  assign busy       = (r_state != S_IDLE);
  assign data_ready = r_data_ready;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    trig_acq_chan #(.DW(DW), .AW(AW)) u_ch (
      .clk      (clk),
      .rstn     (rstn),
      .i_x      (din[g*DW +: DW]),
      .i_thr_lo (thr_lo),
      .i_thr_hi (thr_hi),
      .i_neg    (trig_neg),
      .i_tot    (tot),
      .i_tot_ds (tot_ds),
      .i_ds_go  (w_ds_go),
      .o_trig   (w_chan_trig[g])
    );
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ds_cnt  <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_ext_s1  <= 1'b0;
      r_ext_s2  <= 1'b0;
      r_roll    <= '0;
    end else begin
      r_ds_cnt  <= w_ds_go ? '0 : r_ds_cnt + 1'b1;
      r_wr_en   <= w_ds_go & (r_state != S_IDLE);
      r_wr_data <= din;
      if (r_wr_en) r_wr_addr <= r_wr_addr + 1'b1;
      r_ext_s1  <= ext_trig;
      r_ext_s2  <= r_ext_s1;
      if (w_trig) r_roll <= '0;
      else if (~&r_roll) r_roll <= r_roll + 1'b1;
    end
  end

  // triggers outside WAIT are dropped; arm outside IDLE is dropped
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_trig_addr  <= '0;
      r_data_ready <= 1'b0;
    end else begin
      if (ack) r_data_ready <= 1'b0;
      case (r_state)
        S_IDLE: if (arm) begin
          r_state      <= S_PRE;
          r_data_ready <= 1'b0;
          r_cnt        <= '0;
        end
        S_PRE: begin
          if (r_cnt == pretrig) r_state <= S_WAIT;
          else if (r_wr_en) r_cnt <= r_cnt + 1'b1;
        end
        S_WAIT: if (w_trig) begin
          r_trig_addr <= r_wr_addr;
          r_cnt       <= '0;
          r_state     <= S_POST;
        end
        S_POST: begin
          if (r_cnt == w_post_len) begin
            r_state      <= S_IDLE;
            r_data_ready <= 1'b1;
          end else if (r_wr_en) r_cnt <= r_cnt + 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_trig_acq_ctrl.sv
// Scoreboard bench for trig_acq_ctrl: a behavioural model predicts RAM writes,
// channel triggers and acquisition completions; a monitor matches DUT events.

module tb_trig_acq_ctrl;
  localparam int NCH = 4, DW = 8, AW = 10, DSW = 4, ROLLW = 25;

  logic              clk = 1'b0, rstn = 1'b1;
  logic [NCH*DW-1:0] din = '0;
  logic              arm = 0, ack = 0, trig_neg = 0, tot_ds = 0, rolling = 0;
  logic              ext_trig = 0, ext_en = 0, trig_in = 0;
  logic [DW-1:0]     thr_lo = 8'h80, thr_hi = 8'hFF;
  logic [NCH-1:0]    trig_en = '0;
  logic [AW-1:0]     tot = '0, pretrig = '0, nsmp = '0;
  logic [DSW-1:0]    ds = '0;
  logic [ROLLW-1:0]  roll_period = 25'd100;
  logic              wr_en, selftrig, busy, data_ready;
  logic [AW-1:0]     wr_addr, trig_addr;
  logic [NCH*DW-1:0] wr_data;
  logic [NCH-1:0]    chan_trig;

  trig_acq_ctrl #(.NCH(NCH), .DW(DW), .AW(AW), .DSW(DSW), .ROLLW(ROLLW)) dut (
    .clk(clk), .rstn(rstn), .din(din), .arm(arm), .ack(ack), .thr_lo(thr_lo), .thr_hi(thr_hi),
    .trig_en(trig_en), .trig_neg(trig_neg), .tot(tot), .tot_ds(tot_ds), .ds(ds),
    .pretrig(pretrig), .nsmp(nsmp), .rolling(rolling), .roll_period(roll_period),
    .ext_trig(ext_trig), .ext_en(ext_en), .trig_in(trig_in), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .trig_addr(trig_addr), .chan_trig(chan_trig), .selftrig(selftrig),
    .busy(busy), .data_ready(data_ready));

  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0;
  int din_mode = 0, n_ct0 = 0, last_ct0_cyc = 0;

  typedef struct { int cyc; int addr; logic [NCH*DW-1:0] data; } wr_ev_t;
  typedef struct { int cyc; logic [NCH-1:0] mask; } ct_ev_t;
  typedef struct { int cyc; int taddr; } acq_ev_t;
  wr_ev_t qw[$];
  ct_ev_t qc[$];
  acq_ev_t qa[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  typedef enum {M_IDLE, M_PRE, M_WAIT, M_POST} mst_t;
  mst_t m_st = M_IDLE;
  int m_left = 0, m_addr = 0, m_ta = 0, m_dsc = 0, m_roll = 0;
  int m_run[NCH];
  bit [NCH-1:0] m_h0 = '0, m_h1 = '0, m_ct = '0;
  bit m_we = 0, m_dr = 0, m_e1 = 0, m_e2 = 0;
  logic [NCH*DW-1:0] m_wd = '0;

  function automatic bit m_selftrig();
    return (|(m_ct & trig_en)) || (ext_en && m_e2) || (rolling && (m_roll >= int'(roll_period)));
  endfunction

  task automatic m_reset();
    m_st = M_IDLE; m_left = 0; m_addr = 0; m_ta = 0; m_dsc = 0; m_roll = 0;
    m_h0 = '0; m_h1 = '0; m_ct = '0; m_we = 0; m_dr = 0; m_e1 = 0; m_e2 = 0; m_wd = '0;
    for (int c = 0; c < NCH; c++) m_run[c] = 0;
    qw.delete(); qc.delete(); qa.delete();
  endtask

  task automatic m_step();
    bit dsgo, trig, nwe, odr;
    int postlen;
    bit [NCH-1:0] nct;
    dsgo = (ds == 0) || (m_dsc >= (1 << ds) - 1);
    trig = m_selftrig() || trig_in;
    postlen = (nsmp > pretrig) ? int'(nsmp) - int'(pretrig) : 1;
    nct = '0;
    for (int c = 0; c < NCH; c++) begin
      int x;
      bit inw, edg, cond;
      x = din[c*DW +: DW];
      inw = (x >= thr_lo) && (x <= thr_hi);
      edg = trig_neg ? (!m_h0[c] && m_h1[c]) : (m_h0[c] && !m_h1[c]);
      cond = trig_neg ? !m_h0[c] : m_h0[c];
      if (tot == 0) begin
        nct[c] = edg; m_run[c] = 0;
      end else if (m_run[c] == 0) m_run[c] = edg ? 1 : 0;
      else if (!tot_ds || dsgo) begin
        if (!cond) m_run[c] = 0;
        else if (m_run[c] + 1 > tot) begin nct[c] = 1; m_run[c] = 0; end
        else m_run[c]++;
      end
      m_h1[c] = m_h0[c]; m_h0[c] = inw;
    end
    if (trig) m_roll = 0; else if (m_roll < (1 << ROLLW) - 1) m_roll++;
    nwe = dsgo && (m_st != M_IDLE);
    odr = m_dr;
    if (ack) m_dr = 0;
    case (m_st)
      M_IDLE: if (arm) begin m_st = M_PRE; m_dr = 0; m_left = pretrig; end
      M_PRE:  if (m_left == 0) m_st = M_WAIT; else if (m_we) m_left--;
      M_WAIT: if (trig) begin m_ta = m_addr; m_left = postlen; m_st = M_POST; end
      M_POST: if (m_left == 0) begin m_st = M_IDLE; m_dr = 1; end else if (m_we) m_left--;
    endcase
    m_addr = (m_addr + (m_we ? 1 : 0)) % (1 << AW);
    m_we = nwe;
    m_wd = din;
    m_dsc = dsgo ? 0 : m_dsc + 1;
    m_e2 = m_e1; m_e1 = ext_trig;
    m_ct = nct;
    cyc++;
    if (m_we) qw.push_back('{cyc, m_addr, m_wd});
    if (m_ct != 0) qc.push_back('{cyc, m_ct});
    if (m_dr && !odr) qa.push_back('{cyc, m_ta});
  endtask

  always @(posedge clk or negedge rstn) begin
    if (!rstn) m_reset();
    else m_step();
  end

  // ---------------- monitor ----------------
  bit prev_dr = 0;
  wr_ev_t ew;
  ct_ev_t ec;
  acq_ev_t ea;
  always @(negedge clk) begin
    if (!rstn) prev_dr = 0;
    else begin
      chk("busy", busy, m_st != M_IDLE);
      chk("selftrig", selftrig, m_selftrig());
      if (wr_en) begin
        if (qw.size() == 0) begin checks++; errors++; $display("FAIL wr_unexpected addr %0h", wr_addr); end
        else begin
          ew = qw.pop_front();
          chk("wr_cyc", cyc, ew.cyc); chk("wr_addr", wr_addr, ew.addr); chk("wr_data", wr_data, ew.data);
        end
      end
      if (chan_trig != 0) begin
        if (chan_trig[0]) begin n_ct0++; last_ct0_cyc = cyc; end
        if (qc.size() == 0) begin checks++; errors++; $display("FAIL ct_unexpected got %0h", chan_trig); end
        else begin
          ec = qc.pop_front();
          chk("ct_cyc", cyc, ec.cyc); chk("ct_mask", chan_trig, ec.mask);
        end
      end
      if (data_ready && !prev_dr) begin
        if (qa.size() == 0) begin checks++; errors++; $display("FAIL dr_unexpected taddr %0h", trig_addr); end
        else begin
          ea = qa.pop_front();
          chk("dr_cyc", cyc, ea.cyc); chk("trig_addr", trig_addr, ea.taddr);
        end
      end
      prev_dr = data_ready;
    end
  end

  // ---------------- stimulus ----------------
  task automatic gen_din();
    case (din_mode)
      1: begin
        for (int c = 0; c < NCH; c++)
          if ($urandom_range(0, 3) == 0) begin
            int lo, hi;
            lo = (int'(thr_lo) > 4) ? int'(thr_lo) - 4 : 0;
            hi = (int'(thr_hi) < 251) ? int'(thr_hi) + 4 : 255;
            din[c*DW +: DW] = ($urandom_range(0, 2) != 0) ? DW'($urandom_range(hi, lo)) : DW'($urandom_range(255, 0));
          end
        ext_trig = ($urandom_range(0, 40) == 0);
      end
      2: if (din[DW-1:0] != 8'hFF) din[DW-1:0] = din[DW-1:0] + 8'd1;
      default: ;
    endcase
  endtask

  task automatic tick();
    @(posedge clk); #2; gen_din();
  endtask

  task automatic run_acq(input bit do_arm, input int budget, input int help, input string nm);
    bit done = 0;
    if (do_arm) begin arm = 1; tick(); arm = 0; end
    for (int k = 0; k < budget; k++) begin
      if (data_ready === 1'b1) begin done = 1; break; end
      if (help >= 0 && k >= help) trig_in = 1;
      tick();
    end
    trig_in = 0;
    checks++;
    if (!done) begin errors++; $display("FAIL %s_timeout data_ready %b want 1", nm, data_ready); end
  endtask

  task automatic check_zero(input string nm);
    chk({nm, "_wr_en"}, wr_en, 0);   chk({nm, "_wr_addr"}, wr_addr, 0);
    chk({nm, "_wr_data"}, wr_data, 0); chk({nm, "_trig_addr"}, trig_addr, 0);
    chk({nm, "_chan_trig"}, chan_trig, 0); chk({nm, "_selftrig"}, selftrig, 0);
    chk({nm, "_busy"}, busy, 0);     chk({nm, "_data_ready"}, data_ready, 0);
  endtask

  initial begin
    int n, base, need;
    #1 rstn = 0;
    #1 check_zero("reset");
    repeat (3) tick();
    rstn = 1;
    tick();

    // 1: ramp on ch0 rising through 0x80 while waiting for trigger
    trig_en = 4'b0001; pretrig = 10'd4; nsmp = 10'd10; din = 32'h60; din_mode = 2;
    run_acq(1, 300, -1, "t1");

    // 2: edge latency and time-over-threshold qualification on ch0
    din_mode = 0; din = 32'h10; trig_en = '0; thr_hi = 8'hC0;
    repeat (5) tick();
    n = cyc; din[7:0] = 8'h90; repeat (3) tick(); din[7:0] = 8'h10; repeat (10) tick();
    chk("edge_latency", last_ct0_cyc - n, 2);
    tot = 10'd3; repeat (3) tick();
    base = n_ct0; din[7:0] = 8'h90; repeat (3) tick(); din[7:0] = 8'h10; repeat (10) tick();
    chk("tot_short_pulse", n_ct0 - base, 0);
    n = cyc; din[7:0] = 8'h90; repeat (5) tick(); din[7:0] = 8'h10; repeat (10) tick();
    chk("tot_long_pulse", n_ct0 - base, 1);
    chk("tot_latency", last_ct0_cyc - n, 5);

    // 3: downsampling with ToT on strobes
    ds = 4'd2; tot_ds = 1; tot = 10'd2; trig_en = 4'hF; thr_lo = 8'h60; thr_hi = 8'hA0;
    pretrig = 10'd6; nsmp = 10'd20; din_mode = 1;
    run_acq(1, 2000, 400, "t3");

    // 4: rolling trigger on flat out-of-window input
    ds = 0; tot = 0; tot_ds = 0; trig_en = '0; din_mode = 0; din = '0; thr_lo = 8'h80;
    rolling = 1; roll_period = 25'd100; pretrig = 10'd3; nsmp = 10'd8;
    run_acq(1, 600, -1, "t4");
    rolling = 0;

    // 5: address wrap
    din_mode = 1;
    need = (1016 - m_addr) & 1023;
    if (need < 10) begin pretrig = 10'd500; nsmp = 0; run_acq(1, 2000, 0, "t5pre"); need = (1016 - m_addr) & 1023; end
    pretrig = 10'(need - 5); nsmp = 0;
    run_acq(1, 3000, 0, "t5fill");
    chk("t5_start_addr", wr_addr, m_addr);
    pretrig = 10'd4; nsmp = 10'd10;
    run_acq(1, 300, 0, "t5wrap");
    chk("t5_wrapped", wr_addr < 64, 1);

    // 6: reset mid-POST, recovery, then arm+ack together
    pretrig = 10'd2; nsmp = 10'd40;
    arm = 1; tick(); arm = 0; trig_in = 1;
    for (int k = 0; k < 100 && m_st != M_POST; k++) tick();
    repeat (5) tick();
    chk("t6_busy_before_rst", busy, 1);
    #1 rstn = 0;
    #1 check_zero("mid_post_rst");
    tick(); tick(); rstn = 1; trig_in = 0;
    tick();
    pretrig = 10'd3; nsmp = 10'd7;
    run_acq(1, 300, 20, "t6run");
    arm = 1; ack = 1; tick(); arm = 0; ack = 0;
    chk("armack_busy", busy, 1);
    chk("armack_dr", data_ready, 0);
    run_acq(0, 300, 20, "t6armack");

    // randomized acquisitions
    for (int it = 0; it < 25; it++) begin
      ds = 4'($urandom_range(0, 2)); tot = 10'($urandom_range(0, 4)); tot_ds = 1'($urandom_range(0, 1));
      trig_neg = 1'($urandom_range(0, 1)); thr_lo = 8'($urandom_range(8'h40, 8'h90));
      thr_hi = thr_lo + 8'($urandom_range(0, 8'h50)); trig_en = 4'($urandom_range(0, 15));
      pretrig = 10'($urandom_range(0, 12)); nsmp = 10'($urandom_range(0, 30));
      rolling = ($urandom_range(0, 3) == 0); roll_period = 25'($urandom_range(20, 200));
      ext_en = 1'($urandom_range(0, 1));
      run_acq(1, 3000, 600, "rand");
      if ($urandom_range(0, 1) == 1) begin ack = 1; tick(); ack = 0; end
      repeat ($urandom_range(1, 5)) tick();
    end

    din_mode = 0; ext_trig = 0; rolling = 0; ext_en = 0;
    repeat (8) tick();
    chk("wr_queue_drained", qw.size(), 0);
    chk("ct_queue_drained", qc.size(), 0);
    chk("acq_queue_drained", qa.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
